pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register for the RISC-V core, the general successor to the fixed EX/MEM register. It carries one control vector and one data vector per transfer using a valid/ready handshake, so any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can stall or bubble without bespoke logic. It supports a synchronous flush, forces control bits to zero on bubbles, and counts back-pressure cycles. An optional skid buffer breaks the combinational ready path.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_skid_buf.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - per-boundary vector widths and field offsets for pipeline stage registers
package pipe_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 133;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // EX/MEM data layout, LSB first: rd, pc_plus4, rs2_data, alu_result
  localparam int EXMEM_RD_LSB   = 0;
  localparam int EXMEM_PC4_LSB  = 5;
  localparam int EXMEM_RS2_LSB  = 37;
  localparam int EXMEM_ALU_LSB  = 69;

  // EX/MEM control bit positions
  localparam int EXMEM_REG_WRITE  = 0;
  localparam int EXMEM_MEM_READ   = 1;
  localparam int EXMEM_MEM_WRITE  = 2;
  localparam int EXMEM_MEM_TO_REG = 3;
  localparam int EXMEM_BRANCH     = 4;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } exmem_data_t;

  function automatic logic [EXMEM_DATA_W-1:0] pack_exmem(input exmem_data_t f);
    return f;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry skid register and main-register source mux
// Used by pipe_stage_reg only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              advance,
  input  logic              in_fire,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              skid_valid,
  output logic              sel_valid,
  output logic [CTRL_W-1:0] sel_ctrl,
  output logic [DATA_W-1:0] sel_data
);

  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // The skid entry is older than anything arriving, so it always drains first.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (advance) begin
      skid_valid <= 1'b0;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

  assign sel_valid = skid_valid | in_fire;
  assign sel_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
  assign sel_data  = skid_valid ? skid_data : in_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline stage register with flush and stall counter
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              advance;
  logic              in_fire;
  logic              nxt_valid;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [DATA_W-1:0] nxt_data;

  assign advance = out_ready | ~main_valid;
  assign in_fire = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_valid;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .advance    (advance),
    .in_fire    (in_fire),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .skid_valid (skid_valid),
    .sel_valid  (nxt_valid),
    .sel_ctrl   (nxt_ctrl),
    .sel_data   (nxt_data)
  );

  assign in_ready = ~skid_valid;
`else
  assign in_ready  = advance;
  assign nxt_valid = in_fire;
  assign nxt_ctrl  = in_ctrl;
  assign nxt_data  = in_data;
`endif

  // Payload only loads on a real transfer so a held or bubbled output never changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (advance) begin
      main_valid <= nxt_valid;
      if (nxt_valid) begin
        main_ctrl <= nxt_ctrl;
        main_data <= nxt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  entry_t            q[$];
  logic [DATA_W-1:0] m_last;
  int                m_cnt;
  bit                last_in_fire;
  int                n_vec = 0;
  int                n_err = 0;

  pipe_stage_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input bit r, input bit f, input bit iv, input bit ordy,
                      input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input bit do_chk);
    bit exp_rdy;
    bit fin;
    bit fout;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    #1;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
    if (do_chk) begin
      check_val("out_valid", out_valid, q.size() > 0);
      check_val("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
      check_val("out_data", out_data, (q.size() > 0) ? q[0].d : m_last);
      check_val("in_ready", in_ready, exp_rdy);
      check_val("stall_cnt", stall_cnt, m_cnt);
    end
    fin  = iv && exp_rdy;
    fout = (q.size() > 0) && ordy;
    last_in_fire = fin && !r && !f;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      if (q.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
      if (f) begin
        q.delete();
      end else begin
        if (fout) void'(q.pop_front());
        if (fin) q.push_back('{c: c, d: d});
      end
      if (q.size() > 0) m_last = q[0].d;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 1, 0, 5'h1F, 101'h5, 1);
    step(1, 0, 1, 0, 5'h1F, 101'h5, 1);
  endtask

  initial begin
    logic [127:0] rnd;
    int saved_cnt;
    m_last = '0;
    m_cnt  = 0;

    // Reset held two cycles with an active input offered
    step(1, 0, 1, 0, 5'h1F, 101'h7, 0);
    step(1, 0, 1, 0, 5'h1F, 101'h7, 1);
    #2;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, '0);
    step(0, 0, 0, 0, 5'h00, '0, 1);

    // Streaming, one per cycle
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 1, CTRL_W'(i), DATA_W'(i), 1);
    #2;
    check_val("stream_last", out_data, 101'd8);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, '0, '0, 1);

    // Back-pressure: hold 0xA four cycles while 0xB is offered
    do_reset();
    step(0, 0, 1, 1, 5'h0A, 101'hA, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 5'h0B, 101'hB, 1);
    #2;
    check_val("bp_stall_cnt", stall_cnt, 4'd4);
    check_val("bp_hold", out_data, 101'hA);
    begin
      bit got_b;
      got_b = (CAP == 2);
      for (int i = 0; i < 4; i++) begin
        step(0, 0, !got_b, 1, 5'h0B, 101'hB, 1);
        if (last_in_fire) got_b = 1;
      end
    end

    // Flush while holding 0xA with 0xB transferring in
    do_reset();
    step(0, 0, 1, 1, 5'h0A, 101'hA, 1);
    step(0, 0, 0, 0, '0, '0, 1);
    saved_cnt = m_cnt;
    step(0, 1, 1, 1, 5'h0B, 101'hB, 1);
    #2;
    check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_ctrl", out_ctrl, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0, '0, 1);
    check_val("flush_cnt", stall_cnt, saved_cnt);

    // Stall counter saturation
    do_reset();
    step(0, 0, 1, 1, 5'h03, 101'h33, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0, '0, 1);
    #2;
    check_val("sat_cnt", stall_cnt, 4'd15);

    // Bubbles never leak control bits
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 5'h1F, 101'h1F, 1);
      #2;
      check_val("bubble_ctrl", out_ctrl, '0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           CTRL_W'($urandom), rnd[DATA_W-1:0], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
